// File: rtl/soc_system_led_fader.sv
// LED fader: converts per-channel on/off requests into PWM drive whose
// brightness ramps linearly toward full scale or off, one step per step window.
module soc_system_led_fader #(
  parameter int CHANNELS     = 8,
  parameter int PWM_BITS     = 8,
  parameter int STEP         = 5,
  parameter int STEP_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] led_req,
  output logic [CHANNELS-1:0] led_pwm,
  output logic                busy
);

  localparam int SCNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] MAX_M1    = MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] ZERO      = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS:0]   MAX_W     = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
  localparam logic [SCNT_W-1:0]   SCNT_LAST = SCNT_W'(STEP_PERIODS - 1);

  logic [CHANNELS-1:0] req_q_r;
  logic [PWM_BITS-1:0] cnt_r;
  logic [SCNT_W-1:0]   scnt_r;
  logic [PWM_BITS-1:0] level_r     [CHANNELS];
  logic [PWM_BITS-1:0] level_nxt_s [CHANNELS];
  logic [PWM_BITS:0]   sum_s       [CHANNELS];
  logic [PWM_BITS:0]   diff_s      [CHANNELS];
  logic [CHANNELS-1:0] pwm_nxt_s;
  logic                busy_nxt_s;
  logic                wrap_s;
  logic                step_s;

  // Period boundary and step window detection.
  always_comb begin
    wrap_s = (cnt_r == MAX_M1);
    step_s = wrap_s && (scnt_r == SCNT_LAST);
  end

  // Saturating next level, PWM compare and busy reduction per channel.
  // The extra MSB of diff_s is the borrow, which flags an underflow.
  always_comb begin
    busy_nxt_s = 1'b0;
    pwm_nxt_s  = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sum_s[i]  = {1'b0, level_r[i]} + STEP_W;
      diff_s[i] = {1'b0, level_r[i]} - STEP_W;
      if (req_q_r[i]) begin
        if (sum_s[i] > MAX_W) begin
          level_nxt_s[i] = MAX;
        end else begin
          level_nxt_s[i] = sum_s[i][PWM_BITS-1:0];
        end
      end else begin
        if (diff_s[i][PWM_BITS]) begin
          level_nxt_s[i] = ZERO;
        end else begin
          level_nxt_s[i] = diff_s[i][PWM_BITS-1:0];
        end
      end
      pwm_nxt_s[i] = (level_r[i] > cnt_r);
      if (level_r[i] != (req_q_r[i] ? MAX : ZERO)) begin
        busy_nxt_s = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
  end

  // Input register, PWM/step counters, levels and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q_r <= {CHANNELS{1'b0}};
      cnt_r   <= ZERO;
      scnt_r  <= {SCNT_W{1'b0}};
      led_pwm <= {CHANNELS{1'b0}};
      busy    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        level_r[i] <= ZERO;
      end
    end else begin
      req_q_r <= led_req;
      led_pwm <= pwm_nxt_s;
      busy    <= busy_nxt_s;
      if (wrap_s) begin
        cnt_r <= ZERO;
      end else begin
        cnt_r <= cnt_r + PWM_BITS'(1);
      end
      if (step_s) begin
        scnt_r <= {SCNT_W{1'b0}};
      end else if (wrap_s) begin
        scnt_r <= scnt_r + SCNT_W'(1);
      end else begin
        scnt_r <= scnt_r;
      end
      // Levels move only on the step edge so every PWM period is whole.
      for (int i = 0; i < CHANNELS; i++) begin
        if (step_s) begin
          level_r[i] <= level_nxt_s[i];
        end else begin
          level_r[i] <= level_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_system_led_fader.sv
// Directed bench for soc_system_led_fader: small-parameter ramp, saturation,
// reversal and step-race instances plus one default-parameter instance.
module tb_soc_system_led_fader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_a, req_b, req_c, req_d, req_e;
  logic [7:0] pwm_a, pwm_b, pwm_c, pwm_d, pwm_e;
  logic       busy_a, busy_b, busy_c, busy_d, busy_e;

  always #5 clk = ~clk;

  soc_system_led_fader #(.CHANNELS(8), .PWM_BITS(4), .STEP(5), .STEP_PERIODS(1)) u_a (
    .clk(clk), .reset(reset), .led_req(req_a), .led_pwm(pwm_a), .busy(busy_a));
  soc_system_led_fader #(.CHANNELS(8), .PWM_BITS(4), .STEP(4), .STEP_PERIODS(1)) u_b (
    .clk(clk), .reset(reset), .led_req(req_b), .led_pwm(pwm_b), .busy(busy_b));
  soc_system_led_fader #(.CHANNELS(8), .PWM_BITS(4), .STEP(5), .STEP_PERIODS(1)) u_c (
    .clk(clk), .reset(reset), .led_req(req_c), .led_pwm(pwm_c), .busy(busy_c));
  soc_system_led_fader #(.CHANNELS(8), .PWM_BITS(4), .STEP(5), .STEP_PERIODS(1)) u_d (
    .clk(clk), .reset(reset), .led_req(req_d), .led_pwm(pwm_d), .busy(busy_d));
  soc_system_led_fader u_e (
    .clk(clk), .reset(reset), .led_req(req_e), .led_pwm(pwm_e), .busy(busy_e));

  int checks = 0;
  int errs   = 0;
  int n      = 0;
  int ha, hb, ob, hc, hd_on, hd_off;
  int he, he_all, he_prev, he_last, he_all_last;
  int e_even_lit;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ha = 0; hb = 0; hc = 0; hd_on = 0; hd_off = 0;
  endtask

  // One clock edge, sampled 1 time unit later; windows of 255 edges track the
  // default instance's PWM period.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (pwm_a[0]) ha++;
    if (pwm_b[0]) hb++;
    if (pwm_b[7:1] != 7'd0) ob++;
    if (pwm_c[0]) hc++;
    if (pwm_d == 8'hFF) hd_on++;
    if (pwm_d == 8'h00) hd_off++;
    if (pwm_e[1]) he++;
    if (pwm_e == 8'hAA) he_all++;
    if ((pwm_e & 8'h55) != 8'h00) e_even_lit = 1;
    if (n % 255 == 0) begin
      chk("e_duty_monotonic", int'(he >= he_prev), 1);
      he_prev     = he;
      he_last     = he;
      he_all_last = he_all;
      he          = 0;
      he_all      = 0;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    req_a = 8'h01; req_b = 8'h01; req_c = 8'h01; req_d = 8'h00; req_e = 8'hAA;
    ob = 0; he = 0; he_all = 0; he_prev = 0; he_last = 0; he_all_last = 0;
    e_even_lit = 0;
    clr();
    #22;
    chk("rst_pwm", int'(pwm_a | pwm_b | pwm_c | pwm_d | pwm_e), 0);
    chk("rst_busy", int'(busy_a | busy_b | busy_c | busy_d | busy_e), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;

    // Period 0: no step yet; D's request changes just before the first step edge.
    clr();
    tick();
    chk("a_busy_e1", int'(busy_a), 0);
    tick();
    chk("a_busy_e2", int'(busy_a), 1);
    run(12);
    req_d = 8'hFF;
    tick();
    chk("a_p0", ha, 0);
    chk("b_p0", hb, 0);
    chk("c_p0", hc, 0);
    chk("d_p0_off", hd_off, 15);

    clr(); run(15);
    chk("a_p1", ha, 5);
    chk("b_p1", hb, 4);
    chk("c_p1", hc, 5);
    chk("d_race_p1_on", hd_on, 0);
    chk("d_race_p1_off", hd_off, 15);
    req_c = 8'h00;

    clr(); run(15);
    chk("a_p2", ha, 10);
    chk("b_p2", hb, 8);
    chk("c_p2", hc, 10);
    chk("d_p2_on", hd_on, 5);
    chk("d_p2_off", hd_off, 10);
    chk("a_busy_p2", int'(busy_a), 1);

    clr();
    tick();
    chk("a_busy_fall", int'(busy_a), 0);
    run(14);
    chk("a_p3", ha, 15);
    chk("b_p3", hb, 12);
    chk("c_rev_p3", hc, 5);
    chk("d_p3_on", hd_on, 10);
    chk("c_busy_p3", int'(busy_c), 1);
    req_b = 8'h00;

    clr(); run(15);
    chk("b_sat_p4", hb, 15);
    chk("c_rev_p4", hc, 0);
    chk("c_busy_idle", int'(busy_c), 0);
    chk("d_sat_p4", hd_on, 15);

    clr(); run(15); chk("b_down_p5", hb, 11);
    clr(); run(15); chk("b_down_p6", hb, 7);
    clr(); run(15); chk("b_down_p7", hb, 3);
    clr(); run(15); chk("b_down_p8", hb, 0);
    clr(); run(15);
    chk("b_floor_p9", hb, 0);
    chk("b_busy_idle", int'(busy_b), 0);
    chk("a_hold_p9", ha, 15);
    chk("b_other_ch", ob, 0);

    // Default instance: step 51 lands on edge 52020.
    while (n < 52020) tick();
    chk("e_w203_duty", he_last, 250);
    chk("e_busy_pre", int'(busy_e), 1);
    tick();
    chk("e_busy_done", int'(busy_e), 0);
    while (n < 52275) tick();
    chk("e_full_duty", he_last, 255);
    chk("e_full_all", he_all_last, 255);
    chk("e_even_dark", e_even_lit, 0);

    // Async reset mid-ramp.
    req_c = 8'h01;
    run(35);
    chk("pre_rst_busy_c", int'(busy_c), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_pwm", int'(pwm_a | pwm_b | pwm_c | pwm_d | pwm_e), 0);
    chk("mid_rst_busy", int'(busy_a | busy_b | busy_c | busy_d | busy_e), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0; he = 0; he_all = 0; he_prev = 0;
    clr();
    tick();
    chk("d_busy_e1_rr", int'(busy_d), 0);
    tick();
    chk("d_busy_e2_rr", int'(busy_d), 1);
    run(13);
    chk("d_p0_rr_on", hd_on, 0);
    chk("d_p0_rr_off", hd_off, 15);
    clr(); run(15);
    chk("d_p1_rr_on", hd_on, 5);
    chk("d_p1_rr_off", hd_off, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/soc_system_led_fader.md
# soc_system_led_fader

Downstream consumer of the FPGA LED PIO's 8-bit output port: turns each on/off request bit into a PWM-driven LED whose brightness ramps linearly up or down instead of switching hard. It sits between the LED PIO output and the board LED pins, in the same clock domain as the PIO. It needs no software interaction: the PIO port value alone sets the target brightness of each channel.

## Interface
- CHANNELS, 8, number of LED channels; matches the PIO port width.
- PWM_BITS, 8, brightness resolution. Full-scale level MAX = 2^PWM_BITS-1. PWM period = MAX clock cycles.
- STEP, 5, brightness increment or decrement applied per ramp step; legal range 1..MAX.
- STEP_PERIODS, 4, PWM periods between ramp steps; must be ≥1.

- clk  in  1  system clock, same as the LED PIO.
- reset  in  1  asynchronous, active-high reset.
- led_req  in  CHANNELS  per-channel on request, driven directly by the PIO out_port.
- led_pwm  out  CHANNELS  registered PWM drive to LED pins; 1 = LED lit.
- busy  out  1  registered; 1 while any channel level differs from its target.

## Operation
- Input stage: led_req is registered into req_q every cycle. All decisions use req_q, never raw led_req.
- PWM counter cnt (PWM_BITS wide):
  - Counts 0..MAX-1, then wraps to 0.
  - wrap = (cnt == MAX-1).
- Step counter scnt: counts wraps 0..STEP_PERIODS-1.
  - step = wrap && (scnt == STEP_PERIODS-1).
  - On step, scnt returns to 0.
- Per-channel level[i] (PWM_BITS wide) changes only on the step edge, and therefore only at a PWM period boundary. No partial or glitched periods.
  - req_q[i]=1 and level<MAX: level = min(level+STEP, MAX). Compute at PWM_BITS+1 width, then saturate.
  - req_q[i]=0 and level>0: level = max(level-STEP, 0). Compute as a signed/width-extended subtract, then clamp.
  - Otherwise level holds.
- Output: led_pwm[i] <= (level[i] > cnt), registered.
  - level=0: never lit.
  - level=MAX: constantly lit, since cnt never reaches MAX.
- busy <= OR over i of (level[i] != (req_q[i] ? MAX : 0)), registered.
- A request reversal mid-ramp reverses direction at the next step, continuing from the current level. There is no restart from 0 or MAX.

## Timing
- Reset (async assert, any time including mid-ramp): cnt=0, scnt=0, all level=0, req_q=0, led_pwm=0, busy=0. Normal counting starts on the first clk edge after reset deasserts.
- Latency:
  - led_req to req_q: 1 cycle.
  - req_q affects level only at the next step edge.
  - level/cnt to led_pwm: 1 cycle.
  - busy rises 2 cycles after a led_req change, unless the channel is already at target.
- A led_req change in the cycle of a step edge is not seen by that step (req_q still holds the old value). It takes effect at the following step.
- Step edges occur every STEP_PERIODS*MAX cycles. The first occurs STEP_PERIODS*MAX edges after reset release.
- Full ramp time = ceil(MAX/STEP) steps. With defaults: 51 steps × 4 × 255 = 52020 cycles.
- Channels are independent. Simultaneous up-ramps and down-ramps on different channels update on the same edge.

## Test plan
- Reset values: assert reset mid-operation with levels nonzero and led_pwm toggling -> led_pwm=0x00 and busy=0 immediately (async); cnt restarts from 0 after release.
- Ramp up (PWM_BITS=4, STEP=5, STEP_PERIODS=1, MAX=15): led_req=0x01 from reset. Required response:
  - Period 0 (no step yet): led_pwm[0] high for 0 cycles.
  - Period 1 (level 5): high 5 of 15 cycles.
  - Period 2 (level 10): high 10 of 15 cycles.
  - From period 3 (level 15): constantly high; busy falls on the step edge into period 3 plus 1 cycle.
- Saturation (same params, STEP=4): ramp up -> levels 4, 8, 12, then 15 (not 16/0). Ramp down from 15 -> 11, 7, 3, then 0 (no underflow to 15). Other channels stay 0.
- Reversal: led_req=0x01 until level 10, then led_req=0x00 -> next steps give 5, then 0. busy=0 after reaching 0.
- Step-edge race: change led_req 0x00->0xFF in exactly the cycle of a step edge -> that step leaves all levels at 0. The next step sets all 8 levels to STEP simultaneously.
- Default parameters, led_req=0xAA: channels 1, 3, 5, 7 reach constant high after 52020 cycles from the first step window; channels 0, 2, 4, 6 never lit; duty of a rising channel never decreases between periods.
